key_debounce_encoder: RTL and testbench

Parametrised successor to the combinational keypad map in the candy vending design. It accepts NUM_KEYS raw, asynchronous push-button lines and synchronises them. It debounces a single pressed key and encodes it to a binary selection code. It emits a one-cycle key_valid event per accepted press, so the vending FSM downstream sees exactly one selection per physical press.

---
 rtl/vending_pkg.sv | 14 +
 rtl/key_sync.sv | 24 ++
 rtl/key_debounce_encoder.sv | 103 ++++++++++
 tb/tb_key_debounce_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: shared FSM state encoding and one-hot helpers for the vending input blocks
package vending_pkg;
  localparam int MAX_KEYS = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;
  function automatic logic is_onehot(input logic [MAX_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
  function automatic logic [7:0] onehot_to_code(input logic [MAX_KEYS-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_KEYS; i++) c = v[i] ? c | 8'(i + 1) : c;
    return c;
  endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: W-wide two-flop synchroniser with synchronous reset
//   clk, rst : clock, active-high sync reset
//   d_i      : asynchronous input lines
//   q_o      : second-stage synchronised lines
module key_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder: synchronise, debounce and encode a single pressed key into one event per press
//   clk, rst  : clock, active-high sync reset
//   key_in    : raw asynchronous key lines
//   key_code  : code of last accepted key (bit i -> i+1)
//   key_valid : one-cycle pulse on acceptance
//   key_held  : high from acceptance until release is accepted
//   key_multi : high while idle with more than one key set
module key_debounce_encoder
  import vending_pkg::*;
#(
  parameter int NUM_KEYS        = 6,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_multi
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] s, cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic valid_q, valid_d, held_q, held_d, multi_q, multi_d;
  state_t state_q, state_d;
  key_sync #(.W(NUM_KEYS)) u_sync (.clk(clk), .rst(rst), .d_i(key_in), .q_o(s));
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(MAX_KEYS'(s))) begin
          cand_d  = s;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else begin
          multi_d = s != '0;
        end
      end
      ST_DEBOUNCE: begin
        if (s != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          code_d  = CODE_W'(onehot_to_code(MAX_KEYS'(cand_q)));
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (s != cand_q) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      default: begin
        // any key during release restarts the all-zero stability window
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          held_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign key_multi = multi_q;
endmodule

// File: tb/tb_key_debounce_encoder.sv
// tb_key_debounce_encoder: directed + random stimulus against a run-length reference model, DEBOUNCE_CYCLES 4 and 1
module tb_key_debounce_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] key_in = '0;
  logic [2:0] kc0, kc1;
  logic kv0, kh0, km0, kv1, kh1, km1;
  int errors = 0;
  int checks = 0;
  int pulses0 = 0;
  bit prev_v0 = 0, prev_v1 = 0;

  key_debounce_encoder #(.NUM_KEYS(6), .CODE_W(3), .DEBOUNCE_CYCLES(4), .CNT_W(5)) u0 (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_code(kc0), .key_valid(kv0), .key_held(kh0), .key_multi(km0)
  );
  key_debounce_encoder #(.NUM_KEYS(6), .CODE_W(3), .DEBOUNCE_CYCLES(1), .CNT_W(1)) u1 (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_code(kc1), .key_valid(kv1), .key_held(kh1), .key_multi(km1)
  );

  always #5 clk = ~clk;

  // Model: a press is accepted after d+1 consecutive identical one-hot samples that
  // begin while no key is held; release needs d consecutive all-zero samples after
  // the synchronised lines first differ from the accepted key.
  typedef struct {
    logic [5:0] s1, s2, cand;
    int run, zrun;
    bit held, leaving, valid, multi;
    logic [2:0] code;
  } mdl_t;
  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, logic [5:0] k, bit r, int d);
    logic [5:0] s;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    s = m.s2;
    m.s2 = m.s1;
    m.s1 = k;
    m.valid = 0;
    m.multi = 0;
    if (!m.held) begin
      if (m.run == 0) begin
        m.multi = $countones(s) > 1;
        if ($countones(s) == 1) begin
          m.cand = s;
          m.run = 1;
        end
      end else if (s != m.cand) begin
        m.run = 0;
      end else begin
        m.run++;
        if (m.run == d + 1) begin
          m.valid = 1;
          m.held = 1;
          m.leaving = 0;
          m.run = 0;
          for (int i = 0; i < 6; i++) if (m.cand[i]) m.code = 3'(i + 1);
        end
      end
    end else if (!m.leaving) begin
      if (s != m.cand) begin
        m.leaving = 1;
        m.zrun = 0;
      end
    end else if (s != 0) begin
      m.zrun = 0;
    end else begin
      m.zrun++;
      if (m.zrun == d) m.held = 0;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [5:0] k;
    bit r;
    k = key_in;
    r = rst;
    @(posedge clk);
    m0 = step(m0, k, r, 4);
    m1 = step(m1, k, r, 1);
    #1;
    chk("d4_valid", 8'(kv0), 8'(m0.valid));
    chk("d4_code", 8'(kc0), 8'(m0.code));
    chk("d4_held", 8'(kh0), 8'(m0.held));
    chk("d4_multi", 8'(km0), 8'(m0.multi));
    chk("d1_valid", 8'(kv1), 8'(m1.valid));
    chk("d1_code", 8'(kc1), 8'(m1.code));
    chk("d1_held", 8'(kh1), 8'(m1.held));
    chk("d1_multi", 8'(km1), 8'(m1.multi));
    chk("d4_no_back2back", 8'(kv0 & prev_v0), 8'd0);
    chk("d1_no_back2back", 8'(kv1 & prev_v1), 8'd0);
    prev_v0 = kv0;
    prev_v1 = kv1;
    if (kv0) pulses0++;
  endtask

  task automatic hold(input logic [5:0] v, input int n);
    key_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic latency(input logic [5:0] v, input string tag);
    int lat;
    lat = 99;
    key_in = v;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (kv0) begin
        lat = i;
        break;
      end
    end
    chk(tag, 8'(lat), 8'd7);
  endtask

  initial begin
    int p;
    logic [5:0] v;
    m0 = '{default: 0};
    m1 = '{default: 0};
    tick();
    chk("reset_outputs", {kc0, kv0, kh0, km0, 1'b0}, 8'd0);
    rst = 1'b0;
    hold(6'b000000, 3);
    latency(6'b100000, "single_latency");
    hold(6'b100000, 13);
    chk("single_code", 8'(kc0), 8'd6);
    chk("single_held", 8'(kh0), 8'd1);
    hold(6'b000000, 20);
    chk("single_code_kept", 8'(kc0), 8'd6);
    chk("single_released", 8'(kh0), 8'd0);
    p = pulses0;
    for (int i = 0; i < 6; i++) begin
      hold(6'(1 << i), 20);
      chk("sweep_code", 8'(kc0), 8'(i + 1));
      hold(6'b000000, 20);
    end
    chk("sweep_pulses", 8'(pulses0 - p), 8'd6);
    p = pulses0;
    for (int i = 0; i < 3; i++) begin
      hold(6'b000100, 2);
      hold(6'b000000, 2);
    end
    chk("bounce_no_pulse", 8'(pulses0 - p), 8'd0);
    hold(6'b000100, 20);
    chk("bounce_pulses", 8'(pulses0 - p), 8'd1);
    chk("bounce_code", 8'(kc0), 8'd3);
    hold(6'b000000, 20);
    p = pulses0;
    hold(6'b010010, 15);
    chk("multi_level", 8'(km0), 8'd1);
    chk("multi_no_pulse", 8'(pulses0 - p), 8'd0);
    hold(6'b000010, 20);
    chk("multi_cleared", 8'(km0), 8'd0);
    chk("multi_code", 8'(kc0), 8'd2);
    chk("multi_pulses", 8'(pulses0 - p), 8'd1);
    hold(6'b000000, 20);
    p = pulses0;
    hold(6'b001000, 15);
    hold(6'b001001, 8);
    hold(6'b000000, 3);
    hold(6'b000001, 8);
    chk("reheld_no_pulse", 8'(pulses0 - p), 8'd1);
    chk("reheld_code", 8'(kc0), 8'd4);
    hold(6'b000000, 6);
    hold(6'b000001, 15);
    chk("repress_code", 8'(kc0), 8'd1);
    chk("repress_pulses", 8'(pulses0 - p), 8'd2);
    hold(6'b000000, 20);
    p = pulses0;
    hold(6'b000001, 4);
    rst = 1'b1;
    tick();
    chk("midrst_outputs", {kc0, kv0, kh0, km0, 1'b0}, 8'd0);
    chk("midrst_no_pulse", 8'(pulses0 - p), 8'd0);
    rst = 1'b0;
    latency(6'b000001, "midrst_latency");
    hold(6'b000000, 20);
    for (int i = 0; i < 80; i++) begin
      p = $urandom_range(0, 9);
      v = 6'(1 << $urandom_range(0, 5));
      v = p < 5 ? v : p < 7 ? 6'b000000 : 6'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      hold(v, $urandom_range(1, 10));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
